fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h8000_0180, meaning the exception redirect target.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port stall, input, 1, meaning decode cannot accept; IF/ID holds.
REQ-006 SHALL have port branch_taken, input, 1, meaning a branch redirect request.
REQ-007 SHALL have port branch_target, input, 32, meaning the branch address, already computed as PCplus4 + (signExtImmediate << 2).
REQ-008 SHALL have port jump, input, 1, meaning a jump redirect request.
REQ-009 SHALL have port jump_index, input, 26, meaning the J-type instruction index field.
REQ-010 SHALL have port exception, input, 1, meaning an exception redirect request.
REQ-011 SHALL have port imem_req, output, 1, meaning an instruction memory read request.
REQ-012 SHALL have port imem_addr, output, 32, meaning the fetch address, always equal to the PC register.
REQ-013 SHALL have port imem_ready, input, 1, meaning imem_rdata is valid this cycle for the current imem_addr.
REQ-014 SHALL have port imem_rdata, input, 32, meaning the instruction word.
REQ-015 SHALL have ports ifid_valid (1), ifid_instr (32), ifid_pc (32) and ifid_pcplus4 (32), all outputs, forming the IF/ID register.
REQ-016 SHALL have port misaligned, output, 1, meaning a one-cycle pulse when a redirect target had bits [1:0] != 0.
REQ-017 SHALL have port fetch_count, output, 32, meaning the count of instructions delivered to IF/ID.

Function
REQ-018 SHALL implement states IDLE and FETCH; IDLE SHALL go to FETCH unconditionally on the next edge; FETCH SHALL remain FETCH.
REQ-019 SHALL drive imem_req = (state==FETCH) && !stall, combinationally.
REQ-020 SHALL treat a fetch as accepted when imem_req && imem_ready in a cycle with no redirect.
REQ-021 On acceptance, the next edge SHALL load ifid_instr=imem_rdata, ifid_pc=pc, ifid_pcplus4=pc+4 and ifid_valid=1, set pc=pc+4, and increment fetch_count.
REQ-022 When stall=1, the IF/ID register, pc and fetch_count SHALL hold; a redirect SHALL still apply per REQ-024..REQ-026.
REQ-023 In FETCH with imem_req=1 and imem_ready=0 with no redirect, ifid_valid SHALL go 0 on the next edge and pc SHALL hold (wait states insert bubbles).
REQ-024 Redirect priority SHALL be exception > branch_taken > jump; with stall=1, only exception SHALL be honoured and branch_taken/jump SHALL be ignored.
REQ-025 The redirect targets SHALL be: EXC_VECTOR for exception; branch_target for branch; {ifid_pcplus4[31:28], jump_index, 2'b00} for jump.
REQ-026 A redirect SHALL, on the next edge: load pc with the target; clear ifid_valid; discard any same-cycle imem_ready response; and leave fetch_count unchanged.
REQ-027 A redirect target with bits [1:0] != 0 SHALL be loaded with [1:0] forced to 00, and misaligned SHALL be asserted for exactly the following cycle.
REQ-028 pc+4 SHALL be a 32-bit modulo add: 32'hFFFF_FFFC wraps to 32'h0000_0000. fetch_count SHALL also wrap modulo 2^32.
REQ-029 Redirect inputs in IDLE SHALL apply per REQ-024..REQ-026; the state still goes to FETCH.
REQ-030 All outputs except imem_req SHALL be registered.

Reset
REQ-031 With reset=1 at an edge: pc=RESET_PC, state=IDLE, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pcplus4=0, misaligned=0, fetch_count=0.
REQ-032 Reset SHALL override stall, redirects and imem_ready, and mid-fetch SHALL abandon the outstanding request; imem_req SHALL be 0 in the cycle after reset.

Verification
REQ-033 Reset release, imem_ready=1 always, rdata=addr -> imem_addr 00400000, 00400004, 00400008; ifid_pc follows one cycle later; fetch_count=3 after three accepts.
REQ-034 imem_ready low 2 cycles at 00400004 -> two bubbles (ifid_valid=0), pc holds 00400004, then delivers; fetch_count unaffected by the wait.
REQ-035 branch_taken=1, target 00400100, same cycle imem_ready=1 -> response dropped, ifid_valid=0, next imem_addr=00400100; branch+exception together -> 80000180.
REQ-036 stall=1 for 3 cycles with branch_taken=1 -> imem_req=0, IF/ID and pc unchanged; exception during stall -> pc=80000180 next edge.
REQ-037 jump with ifid_pcplus4=90000010, jump_index=26'h0000041 -> pc=90000104; branch_target=00400102 -> pc=00400100, misaligned pulses one cycle.
REQ-038 pc forced to FFFFFFFC via branch, accept -> next pc 00000000; reset asserted mid-wait -> pc=00400000, state IDLE, ifid_valid=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues instruction memory reads and
// loads the IF/ID pipeline register. Redirects (exception, branch, jump)
// replace the PC and squash any response that arrives in the same cycle.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        exception,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pcplus4,
    output logic        misaligned,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pcplus4_q, ifid_pcplus4_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        accept;

    // Redirect selection: exception always wins; branch and jump are only
    // honoured when decode is not stalled.
    always_comb begin
        redirect        = 1'b0;
        redirect_target = '0;
        if (exception) begin
            redirect        = 1'b1;
            redirect_target = EXC_VECTOR;
        end else if (!stall && branch_taken) begin
            redirect        = 1'b1;
            redirect_target = branch_target;
        end else if (!stall && jump) begin
            redirect        = 1'b1;
            redirect_target = {ifid_pcplus4_q[31:28], jump_index, 2'b00};
        end
    end

    assign imem_req = (state_q == FETCH) && !stall;
    assign accept   = imem_req && imem_ready && !redirect;

    // Next-state computation for the PC, IF/ID register and counters.
    always_comb begin
        state_d        = FETCH;
        pc_d           = pc_q;
        ifid_valid_d   = ifid_valid_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pc_d      = ifid_pc_q;
        ifid_pcplus4_d = ifid_pcplus4_q;
        misaligned_d   = 1'b0;
        fetch_count_d  = fetch_count_q;
        if (redirect) begin
            pc_d         = {redirect_target[31:2], 2'b00};
            ifid_valid_d = 1'b0;
            misaligned_d = |redirect_target[1:0];
        end else if (accept) begin
            ifid_instr_d   = imem_rdata;
            ifid_pc_d      = pc_q;
            ifid_pcplus4_d = pc_q + 32'd4;
            ifid_valid_d   = 1'b1;
            pc_d           = pc_q + 32'd4;
            fetch_count_d  = fetch_count_q + 32'd1;
        end else if (imem_req) begin
            // Wait state: insert a bubble, PC holds.
            ifid_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            ifid_valid_q   <= 1'b0;
            ifid_instr_q   <= '0;
            ifid_pc_q      <= '0;
            ifid_pcplus4_q <= '0;
            misaligned_q   <= 1'b0;
            fetch_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ifid_valid_q   <= ifid_valid_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pc_q      <= ifid_pc_d;
            ifid_pcplus4_q <= ifid_pcplus4_d;
            misaligned_q   <= misaligned_d;
            fetch_count_q  <= fetch_count_d;
        end
    end

    assign imem_addr    = pc_q;
    assign ifid_valid   = ifid_valid_q;
    assign ifid_instr   = ifid_instr_q;
    assign ifid_pc      = ifid_pc_q;
    assign ifid_pcplus4 = ifid_pcplus4_q;
    assign misaligned   = misaligned_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a driver applies directed and random stimulus and
// pushes expected results from a reference model into queues; monitors pop
// and compare against the DUT each cycle.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] EXC_PC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, exception, imem_ready;
    logic [31:0] branch_target, imem_rdata;
    logic [25:0] jump_index;
    logic        imem_req, ifid_valid, misaligned;
    logic [31:0] imem_addr, ifid_instr, ifid_pc, ifid_pcplus4, fetch_count;

    int unsigned errors = 0;
    int unsigned checks = 0;

    fetch_unit #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index), .exception(exception),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_pcplus4(ifid_pcplus4), .misaligned(misaligned),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr, instr, ipc, ip4, cnt;
        logic        v, mis;
    } exp_t;

    exp_t exp_q[$];
    logic req_q[$];

    // Reference model: architectural view of the fetch stage.
    logic        m_init = 1'b0;
    logic        m_fetching;
    logic [31:0] m_pc, m_instr, m_ipc, m_ip4, m_cnt;
    logic        m_v, m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus plus the model's prediction for that edge.
    task automatic cycle(input logic rst, input logic st, input logic br,
                         input logic [31:0] bt, input logic jp,
                         input logic [25:0] ji, input logic ex, input logic rdy);
        logic [31:0] rd, tgt;
        logic        has;
        exp_t        e;
        @(negedge clk);
        rd = $urandom();
        reset = rst; stall = st; branch_taken = br; branch_target = bt;
        jump = jp; jump_index = ji; exception = ex; imem_ready = rdy;
        imem_rdata = rd;
        if (m_init) req_q.push_back(m_fetching && !st);
        if (rst) begin
            m_init = 1'b1; m_fetching = 1'b0; m_pc = RST_PC; m_v = 1'b0;
            m_instr = '0; m_ipc = '0; m_ip4 = '0; m_mis = 1'b0; m_cnt = '0;
        end else begin
            has = 1'b1;
            if (ex)            tgt = EXC_PC;
            else if (!st && br) tgt = bt;
            else if (!st && jp) tgt = {m_ip4[31:28], ji, 2'b00};
            else begin has = 1'b0; tgt = '0; end
            m_mis = 1'b0;
            if (has) begin
                m_pc  = tgt & 32'hFFFF_FFFC;
                m_v   = 1'b0;
                m_mis = (tgt % 4) != 0;
            end else if (m_fetching && !st) begin
                if (rdy) begin
                    m_instr = rd; m_ipc = m_pc; m_ip4 = m_pc + 32'd4;
                    m_v = 1'b1; m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
                end else begin
                    m_v = 1'b0;
                end
            end
            m_fetching = 1'b1;
        end
        e.addr = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.ip4 = m_ip4;
        e.cnt = m_cnt; e.v = m_v; e.mis = m_mis;
        exp_q.push_back(e);
    endtask

    task automatic idle_cyc(input logic rdy);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, rdy);
    endtask

    task automatic sample();
        @(posedge clk); #1;
    endtask

    // Monitor for registered outputs, one expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imem_addr", imem_addr, e.addr);
                chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.v});
                chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
                chk("fetch_count", fetch_count, e.cnt);
                chk("ifid_pc", ifid_pc, e.ipc);
                chk("ifid_pcplus4", ifid_pcplus4, e.ip4);
                chk("ifid_instr", ifid_instr, e.instr);
            end
        end
    end

    // Monitor for the combinational request, sampled mid-cycle.
    initial begin
        logic r;
        forever begin
            @(negedge clk); #2;
            if (req_q.size() > 0) begin
                r = req_q.pop_front();
                chk("imem_req", {31'd0, imem_req}, {31'd0, r});
            end
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_index = '0; exception = 1'b0; imem_ready = 1'b0;
        imem_rdata = '0;

        // Reset, then three back-to-back accepts.
        cycle(1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b1, '1, 1'b1, 1'b1);
        sample();
        chk("rst_pc", imem_addr, RST_PC);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        idle_cyc(1'b1);
        idle_cyc(1'b1); idle_cyc(1'b1); idle_cyc(1'b1);
        sample();
        chk("seq_cnt", fetch_count, 32'd3);
        chk("seq_ifid_pc", ifid_pc, 32'h0040_0008);

        // Wait states at 00400004.
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        idle_cyc(1'b0); idle_cyc(1'b1);
        idle_cyc(1'b0); idle_cyc(1'b0);
        sample();
        chk("wait_pc", imem_addr, 32'h0040_0004);
        chk("wait_valid", {31'd0, ifid_valid}, 32'd0);
        chk("wait_cnt", fetch_count, 32'd1);
        idle_cyc(1'b1);
        sample();
        chk("wait_deliver_pc", ifid_pc, 32'h0040_0004);

        // Branch squashes same-cycle response; exception beats branch.
        cycle(1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0, '0, 1'b0, 1'b1);
        sample();
        chk("br_addr", imem_addr, 32'h0040_0100);
        chk("br_valid", {31'd0, ifid_valid}, 32'd0);
        chk("br_cnt", fetch_count, 32'd2);
        cycle(1'b0, 1'b0, 1'b1, 32'h0040_0200, 1'b0, '0, 1'b1, 1'b1);
        sample();
        chk("exc_prio", imem_addr, EXC_PC);

        // Stall ignores branch but honours exception.
        idle_cyc(1'b1);
        for (int unsigned i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 1'b1, 32'h0040_0300, 1'b0, '0, 1'b0, 1'b1);
        sample();
        chk("stall_pc", imem_addr, 32'h8000_0184);
        chk("stall_valid", {31'd0, ifid_valid}, 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 32'h0040_0300, 1'b0, '0, 1'b1, 1'b1);
        sample();
        chk("stall_exc", imem_addr, EXC_PC);

        // Jump uses ifid_pcplus4 upper bits; misaligned branch target.
        cycle(1'b0, 1'b0, 1'b1, 32'h9000_000C, 1'b0, '0, 1'b0, 1'b0);
        idle_cyc(1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 26'h000_0041, 1'b0, 1'b1);
        sample();
        chk("jump_pc", imem_addr, 32'h9000_0104);
        cycle(1'b0, 1'b0, 1'b1, 32'h0040_0102, 1'b0, '0, 1'b0, 1'b1);
        sample();
        chk("mis_pc", imem_addr, 32'h0040_0100);
        chk("mis_pulse", {31'd0, misaligned}, 32'd1);
        idle_cyc(1'b0);
        sample();
        chk("mis_clear", {31'd0, misaligned}, 32'd0);

        // PC wrap, then reset during a wait.
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0, 1'b0, 1'b0);
        idle_cyc(1'b1);
        sample();
        chk("wrap_pc", imem_addr, 32'h0000_0000);
        chk("wrap_ip4", ifid_pcplus4, 32'h0000_0000);
        idle_cyc(1'b0);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        sample();
        chk("midrst_pc", imem_addr, RST_PC);
        chk("midrst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);

        // Randomized traffic.
        for (int unsigned i = 0; i < 600; i++) begin
            logic [31:0] bt;
            bt = $urandom();
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            cycle($urandom_range(0, 99) < 2,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0,
                  bt,
                  $urandom_range(0, 9) == 0,
                  26'($urandom()),
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 7);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("req_q_drained", req_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
